// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port, byte-wide RAM macro between the two HLS master
// memory lanes of a generated accelerator. Lane requests (oe = read,
// we = write) are serialised with round-robin arbitration. Every access has
// a fixed latency so the timing matches the co-simulation memory model.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   Mout_oe_ram[1:0]      per-lane read request
//   Mout_we_ram[1:0]      per-lane write request
//   Mout_addr_ram         per-lane address, lane0 in the low ADDR_W bits
//   Mout_Wdata_ram        per-lane write data, lane0 in the low DATA_W bits
//   Mout_data_ram_size    per-lane access size in bits, lane0 = [3:0]
//   M_Rdata_ram           per-lane hold register for the last byte read
//   M_DataRdy[1:0]        per-lane single-cycle completion pulse
//   mem_en, mem_we        RAM strobe and write enable, high only in ISSUE
//   mem_addr              RAM address, with BASE_ADDR already subtracted
//   mem_wdata, mem_wmask  RAM write data and bit-write mask
//   mem_rdata             RAM read data, valid the cycle after a read strobe
//   proto_err             sticky: some lane drove oe and we together
//   oob_err               sticky: some lane addressed outside the window
//
// READ_DELAY must be at least 2 and WRITE_DELAY at least 1.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | pick a valid lane (round-robin on a tie), latch its request
// ISSUE  | drive the RAM strobe for exactly one cycle
// WAIT   | count out the rest of the fixed latency, capture read data
// DONE   | pulse DataRdy on the granted lane for one cycle

module ram_port_arbiter #(
    parameter int          ADDR_W      = 12,
    parameter int          DATA_W      = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MEMSIZE     = 2048,
    parameter int          READ_DELAY  = 2,
    parameter int          WRITE_DELAY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [2*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [7:0]            Mout_data_ram_size,
    output logic [2*DATA_W-1:0]   M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  proto_err,
    output logic                  oob_err
);

    localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CNT_W     = $clog2(MAX_DELAY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        req;
    logic [1:0]        both;
    logic [1:0]        in_range;
    logic [1:0]        valid;
    logic [ADDR_W-1:0] lane_off   [2];
    logic [DATA_W-1:0] lane_wdata [2];
    logic [DATA_W-1:0] lane_mask  [2];

    logic              grant_en;
    logic              grant_lane;
    logic              last_grant;
    logic              gnt_lane;
    logic              gnt_op;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic [DATA_W-1:0] gnt_mask;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_target;
    logic [DATA_W-1:0] rdata_hold [2];

    // Bit b is set when b < size, so size 0 gives an empty mask and any
    // size >= DATA_W saturates to all ones.
    function automatic logic [DATA_W-1:0] size_mask(input logic [3:0] size);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < DATA_W; b++) begin
            m[b] = (b < int'(size));
        end
        return m;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [31:0] off;

        // An address below BASE_ADDR wraps to a huge offset, so one
        // unsigned compare covers both ends of the window.
        assign off           = 32'(Mout_addr_ram[g*ADDR_W +: ADDR_W]) - 32'(BASE_ADDR);
        assign in_range[g]   = (off < 32'(MEMSIZE));
        assign lane_off[g]   = off[ADDR_W-1:0];
        assign lane_wdata[g] = Mout_Wdata_ram[g*DATA_W +: DATA_W];
        assign lane_mask[g]  = size_mask(Mout_data_ram_size[g*4 +: 4]);
        assign req[g]        = Mout_oe_ram[g] | Mout_we_ram[g];
        assign both[g]       = Mout_oe_ram[g] & Mout_we_ram[g];
        assign valid[g]      = (Mout_oe_ram[g] ^ Mout_we_ram[g]) & in_range[g];
    end

    assign cnt_target  = gnt_op ? CNT_W'(WRITE_DELAY - 1) : CNT_W'(READ_DELAY - 1);
    assign M_Rdata_ram = {rdata_hold[1], rdata_hold[0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_en   = 1'b0;
        grant_lane = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        M_DataRdy  = 2'b00;

        case (state)
            S_IDLE: begin
                if (valid != 2'b00) begin
                    grant_en   = 1'b1;
                    // On a tie the lane that did not win last time goes next.
                    grant_lane = (valid == 2'b11) ? ~last_grant : valid[1];
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = gnt_op;
                mem_addr  = gnt_addr;
                mem_wdata = gnt_wdata;
                mem_wmask = gnt_mask;
                state_nxt = (gnt_op && (WRITE_DELAY == 1)) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == cnt_target) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                M_DataRdy = gnt_lane ? 2'b10 : 2'b01;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant    <= 1'b1;
            gnt_lane      <= 1'b0;
            gnt_op        <= 1'b0;
            gnt_addr      <= '0;
            gnt_wdata     <= '0;
            gnt_mask      <= '0;
            cnt           <= '0;
            rdata_hold[0] <= '0;
            rdata_hold[1] <= '0;
            proto_err     <= 1'b0;
            oob_err       <= 1'b0;
        end else begin
            proto_err <= proto_err | (|both);
            oob_err   <= oob_err | (|(req & ~in_range));

            if (grant_en) begin
                last_grant <= grant_lane;
                gnt_lane   <= grant_lane;
                gnt_op     <= Mout_we_ram[grant_lane];
                gnt_addr   <= lane_off[grant_lane];
                // Reads ignore size and write data; keep them zero so the
                // RAM sees a clean strobe.
                gnt_wdata  <= Mout_we_ram[grant_lane] ? lane_wdata[grant_lane] : '0;
                gnt_mask   <= Mout_we_ram[grant_lane] ? lane_mask[grant_lane] : '0;
            end

            case (state)
                S_ISSUE: cnt <= CNT_W'(1);
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // mem_rdata is valid exactly one cycle after the strobe.
                    if (!gnt_op && (cnt == CNT_W'(1))) begin
                        rdata_hold[gnt_lane] <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    // Instance A: default window and latencies.
    logic [1:0]  oe_a, we_a, rdy_a;
    logic [23:0] addr_a;
    logic [15:0] wdata_a, rdata_a;
    logic [7:0]  size_a;
    logic        mem_en_a, mem_we_a, proto_a, oob_a;
    logic [11:0] mem_addr_a;
    logic [7:0]  mem_wdata_a, mem_wmask_a, mem_rdata_a;
    logic [7:0]  ram_a [0:4095];

    // Instance B: narrow window at 0x100, longer latencies.
    logic [1:0]  oe_b, we_b, rdy_b;
    logic [23:0] addr_b;
    logic [15:0] wdata_b, rdata_b;
    logic [7:0]  size_b;
    logic        mem_en_b, mem_we_b, proto_b, oob_b;
    logic [11:0] mem_addr_b;
    logic [7:0]  mem_wdata_b, mem_wmask_b, mem_rdata_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ram_port_arbiter dut_a (
        .clock(clock), .reset(reset),
        .Mout_oe_ram(oe_a), .Mout_we_ram(we_a), .Mout_addr_ram(addr_a),
        .Mout_Wdata_ram(wdata_a), .Mout_data_ram_size(size_a),
        .M_Rdata_ram(rdata_a), .M_DataRdy(rdy_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_wmask(mem_wmask_a), .mem_rdata(mem_rdata_a),
        .proto_err(proto_a), .oob_err(oob_a)
    );

    ram_port_arbiter #(
        .BASE_ADDR(32'h100), .MEMSIZE(16), .READ_DELAY(3), .WRITE_DELAY(2)
    ) dut_b (
        .clock(clock), .reset(reset),
        .Mout_oe_ram(oe_b), .Mout_we_ram(we_b), .Mout_addr_ram(addr_b),
        .Mout_Wdata_ram(wdata_b), .Mout_data_ram_size(size_b),
        .M_Rdata_ram(rdata_b), .M_DataRdy(rdy_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_wmask(mem_wmask_b), .mem_rdata(mem_rdata_b),
        .proto_err(proto_b), .oob_err(oob_b)
    );

    // Bit-masked RAM macro model behind instance A.
    always @(posedge clock) begin
        if (mem_en_a) begin
            if (mem_we_a)
                ram_a[mem_addr_a] <= (ram_a[mem_addr_a] & ~mem_wmask_a) | (mem_wdata_a & mem_wmask_a);
            else
                mem_rdata_a <= ram_a[mem_addr_a];
        end
    end

    // Instance B's RAM returns a fixed function of the address.
    always @(posedge clock) begin
        if (mem_en_b && !mem_we_b)
            mem_rdata_b <= 8'h5A ^ mem_addr_b[7:0];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_rdy(input bit sel_b, output int n);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if ((sel_b ? rdy_b : rdy_a) != 2'b00) break;
        end
    endtask

    int n;
    int c0;
    bit seen;

    initial begin
        ram_a[12'h010] <= 8'hA5;
        ram_a[12'h7FF] <= 8'h96;
        ram_a[12'h020] <= 8'h11;
        ram_a[12'h021] <= 8'h22;
        mem_rdata_a = 8'h00;
        mem_rdata_b = 8'h00;
        reset = 1'b1;
        oe_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; size_a = 0;
        oe_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; size_b = 0;
        step();
        step();
        check_val("rst_rdy", rdy_a, 2'b00);
        check_val("rst_mem_en", mem_en_a, 1'b0);
        check_val("rst_rdata", rdata_a, 16'h0000);
        check_val("rst_errs", {proto_a, oob_a}, 2'b00);
        reset = 1'b0;
        step();

        // Lane0 read of 0x010.
        oe_a = 2'b01; addr_a = 24'h000_010;
        step();
        check_val("t1_mem_en", mem_en_a, 1'b1);
        check_val("t1_mem_we", mem_we_a, 1'b0);
        check_val("t1_mem_addr", mem_addr_a, 12'h010);
        step();
        check_val("t1_wait_rdy", rdy_a, 2'b00);
        check_val("t1_wait_en", mem_en_a, 1'b0);
        step();
        check_val("t1_rdy", rdy_a, 2'b01);
        check_val("t1_rdata", rdata_a[7:0], 8'hA5);
        step();
        oe_a = 2'b00;
        check_val("t1_rdy_pulse", rdy_a, 2'b00);
        step();
        check_val("t1_rdata_hold", rdata_a[7:0], 8'hA5);

        // Lane1 nibble write to 0x7FF, then read back.
        we_a = 2'b10; addr_a = 24'h7FF_000; wdata_a = 16'h3C00; size_a = 8'h40;
        step();
        check_val("t2_mem_en", {mem_en_a, mem_we_a}, 2'b11);
        check_val("t2_wmask", mem_wmask_a, 8'h0F);
        check_val("t2_wdata", mem_wdata_a, 8'h3C);
        check_val("t2_addr", mem_addr_a, 12'h7FF);
        step();
        check_val("t2_rdy", rdy_a, 2'b10);
        step();
        we_a = 2'b00;
        oe_a = 2'b10;
        wait_rdy(1'b0, n);
        check_val("t2_rb_lat", n, 3);
        check_val("t2_rb_rdy", rdy_a, 2'b10);
        check_val("t2_rb_data", rdata_a[15:8], 8'h9C);
        check_val("t2_lane0_kept", rdata_a[7:0], 8'hA5);
        step();
        oe_a = 2'b00;
        step();

        // Both lanes read together straight after reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        oe_a = 2'b11; addr_a = 24'h021_020;
        wait_rdy(1'b0, n);
        c0 = cyc;
        check_val("t3_first_lat", n, 3);
        check_val("t3_first_rdy", rdy_a, 2'b01);
        check_val("t3_lane0_data", rdata_a[7:0], 8'h11);
        step();
        oe_a = 2'b10;
        wait_rdy(1'b0, n);
        check_val("t3_second_rdy", rdy_a, 2'b10);
        check_val("t3_spacing", cyc - c0, 4);
        check_val("t3_lane1_data", rdata_a[15:8], 8'h22);
        step();
        oe_a = 2'b00;
        step();

        // Lane0 drives oe and we together.
        oe_a = 2'b01; we_a = 2'b01; addr_a = 24'h000_005;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_en_a || (rdy_a != 2'b00)) seen = 1'b1;
        end
        check_val("t4_no_access", seen, 1'b0);
        check_val("t4_proto_err", proto_a, 1'b1);
        check_val("t4_oob_clear", oob_a, 1'b0);
        oe_a = 2'b00; we_a = 2'b00;
        step();
        step();
        check_val("t4_proto_sticky", proto_a, 1'b1);

        // Reset in the middle of a lane0 read.
        oe_a = 2'b01; addr_a = 24'h000_010;
        step();
        step();
        reset = 1'b1;
        oe_a = 2'b00;
        step();
        check_val("t6_mem_en", mem_en_a, 1'b0);
        check_val("t6_rdy", rdy_a, 2'b00);
        check_val("t6_rdata", rdata_a, 16'h0000);
        check_val("t6_proto", proto_a, 1'b0);
        reset = 1'b0;
        step();
        check_val("t6_no_late_rdy", rdy_a, 2'b00);
        oe_a = 2'b11; addr_a = 24'h7FF_010;
        wait_rdy(1'b0, n);
        check_val("t6_prio_rdy", rdy_a, 2'b01);
        check_val("t6_prio_lat", n, 3);
        check_val("t6_lane0_data", rdata_a[7:0], 8'hA5);
        step();
        oe_a = 2'b10;
        wait_rdy(1'b0, n);
        check_val("t6_lane1_rdy", rdy_a, 2'b10);
        check_val("t6_lane1_data", rdata_a[15:8], 8'h9C);
        step();
        oe_a = 2'b00;
        step();

        // Instance B: out-of-window request, then in-window accesses.
        oe_b = 2'b10; addr_b = 24'h120_000;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_en_b || (rdy_b != 2'b00)) seen = 1'b1;
        end
        check_val("t5_no_access", seen, 1'b0);
        check_val("t5_oob_err", oob_b, 1'b1);
        check_val("t5_proto_clear", proto_b, 1'b0);
        oe_b = 2'b00;
        step();
        oe_b = 2'b10; addr_b = 24'h10F_000;
        step();
        check_val("t5_mem_en", mem_en_b, 1'b1);
        check_val("t5_mem_addr", mem_addr_b, 12'h00F);
        wait_rdy(1'b1, n);
        check_val("t5_rd_lat", n, 3);
        check_val("t5_rdy", rdy_b, 2'b10);
        check_val("t5_rdata", rdata_b[15:8], 8'h55);
        step();
        oe_b = 2'b00;
        we_b = 2'b01; addr_b = 24'h000_100; wdata_b = 16'h00E7; size_b = 8'h00;
        step();
        check_val("t5_w0_strobe", {mem_en_b, mem_we_b}, 2'b11);
        check_val("t5_w0_mask", mem_wmask_b, 8'h00);
        check_val("t5_w0_addr", mem_addr_b, 12'h000);
        wait_rdy(1'b1, n);
        check_val("t5_w0_lat", n, 2);
        check_val("t5_w0_rdy", rdy_b, 2'b01);
        step();
        we_b = 2'b00;
        step();
        we_b = 2'b01; addr_b = 24'h000_10F; size_b = 8'h0F;
        step();
        check_val("t5_wf_mask", mem_wmask_b, 8'hFF);
        check_val("t5_wf_data", mem_wdata_b, 8'hE7);
        wait_rdy(1'b1, n);
        check_val("t5_wf_rdy", rdy_b, 2'b01);
        step();
        we_b = 2'b00;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
